// File: rtl/oc8051_muldiv_seq.sv
// Sequential radix-2 MUL AB / DIV AB engine: one bit per clock, start/busy/done handshake.
// Multiply is shift-add LSB-first; divide is restoring MSB-first. Both share one hi/lo shift pair.
module oc8051_muldiv_seq #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          op_div,
    input  logic [DW-1:0] src1,
    input  logic [DW-1:0] src2,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] des1,
    output logic [DW-1:0] des2,
    output logic          desOv
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          is_div;
    logic [DW-1:0] opnd;
    logic [DW-1:0] hi, lo;
    logic          load;
    logic          last_iter;

    logic [DW:0]   mul_sum;
    logic [DW:0]   rem_sh;
    logic [DW+1:0] trial;
    logic          div_ge;
    logic [DW-1:0] hi_nxt, lo_nxt;

    assign last_iter = (cnt == CW'(DW - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_nxt = FIN;
            end
            FIN: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Remainder shifted left can reach DW+1 bits, so the trial keeps an extra borrow bit.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(DW+1){1'b0}});
        rem_sh  = {hi, lo[DW-1]};
        trial   = {1'b0, rem_sh} - {2'b00, opnd};
        div_ge  = ~trial[DW+1];
        if (is_div) begin
            hi_nxt = div_ge ? trial[DW-1:0] : rem_sh[DW-1:0];
            lo_nxt = {lo[DW-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[DW:1];
            lo_nxt = {mul_sum[0], lo[DW-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            des1   <= '0;
            des2   <= '0;
            desOv  <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            is_div <= op_div;
            opnd   <= op_div ? src2 : src1;
            lo     <= op_div ? src1 : src2;
            hi     <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            if (last_iter) begin
                des1  <= lo_nxt;
                des2  <= hi_nxt;
                desOv <= is_div ? (opnd == '0) : (hi_nxt != '0);
            end
        end
    end

endmodule

// File: tb/tb_oc8051_muldiv_seq.sv
// Self-checking bench for oc8051_muldiv_seq: timestamp-based reference model compared every cycle,
// directed literal cases, then randomized start/op/operand/reset traffic.
module tb_oc8051_muldiv_seq;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          op_div = 1'b0;
    logic [DW-1:0] src1 = '0;
    logic [DW-1:0] src2 = '0;
    logic          busy, done, desOv;
    logic [DW-1:0] des1, des2;

    int total = 0;
    int bad   = 0;
    logic chk = 1'b0;

    oc8051_muldiv_seq #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .op_div(op_div),
        .src1(src1), .src2(src2), .busy(busy), .done(done),
        .des1(des1), .des2(des2), .desOv(desOv)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference model: an accepted operation finishes DW edges after its accept edge.
    int            cyc = 0;
    int            m_tacc = 0;
    logic          m_active = 1'b0;
    logic          m_busy = 1'b0, m_done = 1'b0, m_ov = 1'b0;
    logic [DW-1:0] m_d1 = '0, m_d2 = '0;
    logic [DW-1:0] p_d1 = '0, p_d2 = '0;
    logic          p_ov = 1'b0;

    always @(posedge clk) begin
        logic [2*DW-1:0] prod;
        cyc++;
        if (rst) begin
            m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_d1 = '0; m_d2 = '0; m_ov = 1'b0;
        end else begin
            if (m_active && (cyc - m_tacc) == DW) begin
                m_d1 = p_d1; m_d2 = p_d2; m_ov = p_ov;
            end
            if (start && !m_busy) begin
                m_tacc   = cyc;
                m_active = 1'b1;
                if (op_div) begin
                    if (src2 == 0) begin
                        p_d1 = '1; p_d2 = src1; p_ov = 1'b1;
                    end else begin
                        p_d1 = src1 / src2; p_d2 = src1 % src2; p_ov = 1'b0;
                    end
                end else begin
                    prod = src1 * src2;
                    p_d1 = prod[DW-1:0]; p_d2 = prod[2*DW-1:DW]; p_ov = (prod[2*DW-1:DW] != 0);
                end
            end else if (m_active && (cyc - m_tacc) > DW) begin
                m_active = 1'b0;
            end
            m_busy = m_active && (cyc - m_tacc) < DW;
            m_done = m_active && (cyc - m_tacc) == DW;
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("busy",  busy,  m_busy);
            check("done",  done,  m_done);
            check("des1",  des1,  m_d1);
            check("des2",  des2,  m_d2);
            check("desOv", desOv, m_ov);
        end
    end

    task automatic run_op(input logic d, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] e1, input logic [DW-1:0] e2, input logic eov,
                          input int noise_at, input logic b2b, input string nm);
        int n;
        if (!b2b) @(negedge clk);
        start = 1'b1; op_div = d; src1 = a; src2 = b;
        @(negedge clk);
        start = 1'b0; op_div = ~d; src1 = DW'($urandom); src2 = DW'($urandom);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (noise_at != 0 && n == noise_at) begin
                start = 1'b1; op_div = 1'b1; src1 = 8'h05; src2 = 8'h07;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({nm, "_lat"},   n,     9);
        check({nm, "_des1"},  des1,  e1);
        check({nm, "_des2"},  des2,  e2);
        check({nm, "_ov"},    desOv, eov);
        check({nm, "_model"}, m_d1,  e1);
    endtask

    initial begin
        int n_done;
        repeat (3) @(negedge clk);
        chk = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_des1", des1, 0);
        check("rst_ov",   desOv, 0);
        rst = 1'b0;

        run_op(1'b0, 8'h12, 8'h34, 8'hA8, 8'h03, 1'b1, 0, 1'b0, "mul_12x34");
        run_op(1'b0, 8'h0F, 8'h11, 8'hFF, 8'h00, 1'b0, 0, 1'b0, "mul_0fx11");
        run_op(1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 0, 1'b0, "mul_ffxff");
        run_op(1'b0, 8'h00, 8'hC3, 8'h00, 8'h00, 1'b0, 0, 1'b0, "mul_zero");
        run_op(1'b1, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0, 0, 1'b0, "div_fb_12");
        run_op(1'b1, 8'h05, 8'h07, 8'h00, 8'h05, 1'b0, 0, 1'b0, "div_05_07");
        run_op(1'b1, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 0, 1'b0, "div_by0");
        run_op(1'b0, 8'h12, 8'h34, 8'hA8, 8'h03, 1'b1, 4, 1'b0, "ignored_restart");
        run_op(1'b0, 8'h02, 8'h03, 8'h06, 8'h00, 1'b0, 0, 1'b1, "b2b");

        // Reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op_div = 1'b1; src1 = 8'hFB; src2 = 8'h12;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_des1", des1, 0);
        check("abort_des2", des2, 0);
        check("abort_ov",   desOv, 0);
        rst = 1'b0;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // Reset wins over start on the same edge.
        rst = 1'b1; start = 1'b1; op_div = 1'b0; src1 = 8'h03; src2 = 8'h04;
        @(negedge clk);
        check("rst_start_busy", busy, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_idle", busy, 0);

        // Random traffic: sparse starts (some during busy), zero divisors, occasional reset.
        for (int i = 0; i < 2000; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            op_div = 1'($urandom);
            src1   = ($urandom_range(0, 7) == 0) ? 8'h00 : DW'($urandom);
            src2   = ($urandom_range(0, 7) == 0) ? 8'h00 : DW'($urandom);
            rst    = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        start = 1'b0; rst = 1'b0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
